// File: rtl/jpeg_tp_pkg.sv
// Shared types and constants for the 8x8 ping-pong transpose buffer.
// Widths default to the JPEG coefficient size.
package jpeg_tp_pkg;

    localparam int COEF_W_DEFAULT = 12;
    localparam int N              = 8;
    localparam int IDX_W          = $clog2(N);

    typedef logic [COEF_W_DEFAULT-1:0] coef_t;
    typedef coef_t [N-1:0]             vec_t;
    typedef logic [IDX_W-1:0]          idx_t;

    // Number of full banks in a two-bank buffer.
    function automatic logic [1:0] count_full(input logic [1:0] full);
        return {1'b0, full[0]} + {1'b0, full[1]};
    endfunction

endpackage

// File: rtl/tp_bank.sv
// One 8x8 coefficient bank: whole column written per cycle, whole row read
// combinationally. This bank is where the transpose happens.
module tp_bank
    import jpeg_tp_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  idx_t                i_wr_col,
    input  logic [N*COEF_W-1:0] i_wr_data,
    input  idx_t                i_rd_row,
    output logic [N*COEF_W-1:0] o_rd_data
);

    logic [COEF_W-1:0] r_mem [N][N];  // [row][col]

    // NOTE: bank storage has no reset; a stale block is never visible because
    // the full flags in the top gate every read.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int r = 0; r < N; r++) begin
                r_mem[r][i_wr_col] <= i_wr_data[COEF_W*r +: COEF_W];
            end
        end
    end

    // NOTE: combinational outputs get a default first so no latch is inferred.
    always_comb begin
        o_rd_data = '0;
        for (int c = 0; c < N; c++) begin
            o_rd_data[COEF_W*c +: COEF_W] = r_mem[i_rd_row][c];
        end
    end

endmodule

// File: rtl/transpose_pp.sv
// Ping-pong 8x8 transpose: eight column words in, eight row words out per block.
// Handshake control (pointers, counters, full flags) lives here; data lives in tp_bank.
module transpose_pp
    import jpeg_tp_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*COEF_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*COEF_W-1:0] out_data,
    output logic                out_last,
    output logic [1:0]          occupancy
);

    logic [1:0] r_full;
    logic       r_wb;
    logic       r_rb;
    idx_t       r_wcol;
    idx_t       r_rrow;
    logic [1:0] r_occ;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_blk_done;
    logic                w_drain_done;
    logic [1:0]          w_full_nxt;
    logic [1:0]          w_wr_en;
    logic [N*COEF_W-1:0] w_row [2];

    assign in_ready     = ~r_full[r_wb];
    assign out_valid    = r_full[r_rb];
    assign w_in_fire    = in_valid & in_ready;
    assign w_out_fire   = out_valid & out_ready;
    assign w_blk_done   = w_in_fire  && (r_wcol == idx_t'(N-1));
    assign w_drain_done = w_out_fire && (r_rrow == idx_t'(N-1));

    // Write and read always target different banks when both complete together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_blk_done) begin
            w_full_nxt[r_wb] = 1'b1;
        end
        if (w_drain_done) begin
            w_full_nxt[r_rb] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= '0;
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_wcol <= '0;
            r_rrow <= '0;
            r_occ  <= '0;
        end else begin
            r_full <= w_full_nxt;
            r_occ  <= count_full(w_full_nxt);
            if (w_in_fire) begin
                r_wcol <= w_blk_done ? '0 : r_wcol + idx_t'(1);
            end
            if (w_blk_done) begin
                r_wb <= ~r_wb;
            end
            if (w_out_fire) begin
                r_rrow <= w_drain_done ? '0 : r_rrow + idx_t'(1);
            end
            if (w_drain_done) begin
                r_rb <= ~r_rb;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_wr_en[b] = w_in_fire && (r_wb == 1'(b));

        tp_bank #(
            .COEF_W (COEF_W)
        ) u_bank (
            .clk       (clk),
            .i_wr_en   (w_wr_en[b]),
            .i_wr_col  (r_wcol),
            .i_wr_data (in_data),
            .i_rd_row  (r_rrow),
            .o_rd_data (w_row[b])
        );
    end

    assign out_data  = out_valid ? w_row[r_rb] : '0;
    assign out_last  = out_valid && (r_rrow == idx_t'(N-1));
    assign occupancy = r_occ;

    a_bank_collision: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_in_fire && w_out_fire && (r_wb == r_rb)));

endmodule

// File: tb/tb_transpose_pp.sv
// Bench for transpose_pp: a queue-based block model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_transpose_pp;
    import jpeg_tp_pkg::*;

    localparam int W  = COEF_W_DEFAULT;
    localparam int DW = N * W;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

    transpose_pp #(.COEF_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .occupancy (occupancy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // Element (r,c) of block blk = blk*256 + 16*r + c.
    function automatic logic [DW-1:0] col_word(input int blk, input int c);
        logic [DW-1:0] v;
        for (int r = 0; r < N; r++) v[W*r +: W] = W'(blk*256 + r*16 + c);
        return v;
    endfunction

    function automatic logic [DW-1:0] row_word(input int blk, input int r);
        logic [DW-1:0] v;
        for (int c = 0; c < N; c++) v[W*c +: W] = W'(blk*256 + r*16 + c);
        return v;
    endfunction

    // Model: columns collect into cur; a completed block is transposed into
    // eight expected rows. A block counts as full from its last column until
    // its last row leaves.
    logic [DW-1:0] exp_q[$];
    logic [W-1:0]  cur [N][N];
    int            part        = 0;
    int            blocks_full = 0;
    int            rows_out    = 0;
    int            max_occ     = 0;
    logic          prev_stall  = 1'b0;
    logic [DW-1:0] prev_data   = '0;

    always @(negedge clk) begin : compare
        logic [DW-1:0] rw;
        if (!rst_n) begin
            exp_q.delete();
            part        = 0;
            blocks_full = 0;
            rows_out    = 0;
            prev_stall  = 1'b0;
        end else begin
            check("in_ready",  DW'(in_ready),  DW'(blocks_full < 2));
            check("out_valid", DW'(out_valid), DW'(blocks_full > 0));
            check("occupancy", DW'(occupancy), DW'(blocks_full));
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            if (prev_stall) check("stall_hold", out_data, prev_data);
            if (blocks_full > 0 && exp_q.size() > 0) begin
                check("out_data", out_data, exp_q[0]);
                check("out_last", DW'(out_last), DW'(rows_out == N-1));
            end else begin
                check("idle_data", out_data, '0);
                check("idle_last", DW'(out_last), '0);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                rows_out++;
                if (rows_out == N) begin
                    rows_out = 0;
                    blocks_full--;
                end
            end
            if (in_valid && in_ready) begin
                for (int r = 0; r < N; r++) cur[r][part] = in_data[W*r +: W];
                part++;
                if (part == N) begin
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) rw[W*c +: W] = cur[r][c];
                        exp_q.push_back(rw);
                    end
                    blocks_full++;
                    part = 0;
                end
            end
        end
    end

    int stall_cycles = 0;

    // Offers one column and returns #1 after the edge that accepted it.
    task automatic send_col(input int blk, input int c, input bit gaps);
        int n = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = col_word(blk, c);
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
            stall_cycles++;
        end
        if (!in_ready) timeout_fail("send_col");
        else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        out_ready = 1'b1;
        while ((out_valid || blocks_full != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) timeout_fail("drain");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    bit done;

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready",  DW'(in_ready),  DW'(1));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data",  out_data,       '0);
        check("rst_out_last",  DW'(out_last),  DW'(0));
        check("rst_occupancy", DW'(occupancy), DW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single block, consumer always ready.
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) send_col(0, c, 1'b0);
        in_valid = 1'b0;
        check("t1_valid_lat1", DW'(out_valid), DW'(1));
        check("t1_row0", out_data, 96'h007006005004003002001000);
        repeat (3) begin @(posedge clk); #1; end
        check("t1_row3", out_data, 96'h037036035034033032031030);
        check("t1_row3_last", DW'(out_last), DW'(0));
        repeat (4) begin @(posedge clk); #1; end
        check("t1_row7", out_data, 96'h077076075074073072071070);
        check("t1_row7_last", DW'(out_last), DW'(1));
        @(posedge clk); #1;
        check("t1_empty_valid", DW'(out_valid), DW'(0));

        // Four blocks streamed back to back.
        stall_cycles = 0;
        max_occ      = 0;
        for (int b = 1; b <= 4; b++)
            for (int c = 0; c < N; c++) send_col(b, c, 1'b0);
        in_valid = 1'b0;
        check("t2_no_stall", DW'(stall_cycles), DW'(0));
        wait_drain();
        check("t2_max_occ", DW'(max_occ), DW'(1));

        // Consumer stalled: two blocks fill both banks, the third waits.
        out_ready = 1'b0;
        for (int b = 5; b <= 6; b++)
            for (int c = 0; c < N; c++) send_col(b, c, 1'b0);
        in_valid = 1'b1;
        in_data  = col_word(7, 0);
        check("t3_ready_low", DW'(in_ready), DW'(0));
        check("t3_occ2", DW'(occupancy), DW'(2));
        repeat (3) begin @(posedge clk); #1; end
        check("t3_still_low", DW'(in_ready), DW'(0));
        out_ready = 1'b1;
        repeat (7) begin @(posedge clk); #1; end
        check("t3_low_before_row7", DW'(in_ready), DW'(0));
        @(posedge clk); #1;
        check("t3_ready_after_row7", DW'(in_ready), DW'(1));
        check("t3_occ1", DW'(occupancy), DW'(1));
        for (int c = 0; c < N; c++) send_col(7, c, 1'b0);
        in_valid = 1'b0;
        wait_drain();

        // Random valid/ready at 50 percent.
        done = 1'b0;
        fork
            begin
                for (int b = 8; b <= 11; b++)
                    for (int c = 0; c < N; c++) send_col(b, c, 1'b1);
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        wait_drain();

        // Reset while block 12 drains row 2 and block 13 has 5 columns.
        out_ready = 1'b0;
        for (int c = 0; c < N; c++) send_col(12, c, 1'b0);
        out_ready = 1'b1;
        send_col(13, 0, 1'b0);
        send_col(13, 1, 1'b0);
        out_ready = 1'b0;
        for (int c = 2; c < 5; c++) send_col(13, c, 1'b0);
        in_valid = 1'b0;
        check("t5_pre_row2", out_data, row_word(12, 2));
        rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready",  DW'(in_ready),  DW'(1));
        check("t5_rst_out_valid", DW'(out_valid), DW'(0));
        check("t5_rst_out_data",  out_data,       '0);
        check("t5_rst_out_last",  DW'(out_last),  DW'(0));
        check("t5_rst_occupancy", DW'(occupancy), DW'(0));
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stall_cycles = 0;
        for (int c = 0; c < N; c++) send_col(14, c, 1'b0);
        in_valid = 1'b0;
        check("t5_accept_immediately", DW'(stall_cycles), DW'(0));
        check("t5_new_valid", DW'(out_valid), DW'(1));
        check("t5_new_row0", out_data, row_word(14, 0));
        wait_drain();

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
